// File: rtl/ht_pkg.sv
// Shared encodings for the open-addressing probe table: commands, status codes, FSM states.
package ht_pkg;

  typedef enum logic [1:0] {
    CMD_LOOKUP = 2'b00,
    CMD_INSERT = 2'b01,
    CMD_DELETE = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_OK   = 2'b01,
    ST_MISS = 2'b10,
    ST_FULL = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PROBE = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic logic state_busy(state_e s);
    return s != S_IDLE;
  endfunction

endpackage

// File: rtl/ht_hash.sv
// Combinational slot hash: XOR-fold of DEPTH_LOG2-bit key chunks, or the low key bits.
module ht_hash #(
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned HASH_MODE  = 0
) (
  input  logic [KEY_W-1:0]      key_i,
  output logic [DEPTH_LOG2-1:0] hash_o
);

  localparam int unsigned NCHUNK = (KEY_W + DEPTH_LOG2 - 1) / DEPTH_LOG2;
  localparam int unsigned PADW   = NCHUNK * DEPTH_LOG2;

  generate
    if (HASH_MODE == 0) begin : g_xor
      // Zero-extending the key pads the top chunk at its MSBs.
      logic [PADW-1:0] key_pad;
      assign key_pad = PADW'(key_i);

      always_comb begin
        hash_o = '0;
        for (int c = 0; c < int'(NCHUNK); c++) begin
          hash_o = hash_o ^ key_pad[c*DEPTH_LOG2 +: DEPTH_LOG2];
        end
      end
    end else if (KEY_W >= DEPTH_LOG2) begin : g_low
      assign hash_o = key_i[DEPTH_LOG2-1:0];
    end else begin : g_low_ext
      assign hash_o = DEPTH_LOG2'(key_i);
    end
  endgenerate

endmodule

// File: rtl/param_probe_table.sv
// Linear-probing hash table in flops with LOOKUP/INSERT/DELETE/CLEAR, one slot examined per cycle.
module param_probe_table
  import ht_pkg::*;
#(
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned VAL_W      = 4,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned HASH_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd,
  input  logic                  go,
  input  logic [KEY_W-1:0]      key,
  input  logic [VAL_W-1:0]      val,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [VAL_W-1:0]      out,
  output logic [DEPTH_LOG2:0]   probes
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DW    = DEPTH_LOG2;

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  status_e           status_q, status_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic [VAL_W-1:0]  out_q, out_d;
  logic [DW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     rem_idx_q, rem_idx_d;
  logic              rem_vld_q, rem_vld_d;
  logic [PW-1:0]     count_q, count_d;
  logic [PW-1:0]     probes_q, probes_d;
  logic              go_prev_q;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  tomb_q, tomb_d;

  logic [KEY_W-1:0]  key_mem_q [DEPTH];
  logic [VAL_W-1:0]  val_mem_q [DEPTH];

  logic [DW-1:0]     hash_c;
  logic              accept_c;
  logic              wr_en_c;
  logic [DW-1:0]     wr_idx_c;
  logic              slot_vld_c, slot_tomb_c, slot_empty_c, slot_match_c, last_c;
  logic [PW-1:0]     cnt_next_c;

  ht_hash #(
    .KEY_W      (KEY_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .HASH_MODE  (HASH_MODE)
  ) u_hash (
    .key_i  (key),
    .hash_o (hash_c)
  );

  assign accept_c     = (state_q == S_IDLE) && go && !go_prev_q;
  assign slot_vld_c   = valid_q[idx_q];
  assign slot_tomb_c  = tomb_q[idx_q];
  assign slot_empty_c = !slot_vld_c && !slot_tomb_c;
  assign slot_match_c = slot_vld_c && (key_mem_q[idx_q] == key_q);
  assign cnt_next_c   = count_q + PW'(1);
  assign last_c       = (cnt_next_c == PW'(DEPTH));

  // Next-state, termination decisions and slot write strobes.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    status_d  = status_q;
    key_d     = key_q;
    val_d     = val_q;
    out_d     = out_q;
    idx_d     = idx_q;
    rem_idx_d = rem_idx_q;
    rem_vld_d = rem_vld_q;
    count_d   = count_q;
    probes_d  = probes_q;
    valid_d   = valid_q;
    tomb_d    = tomb_q;
    wr_en_c   = 1'b0;
    wr_idx_c  = idx_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cmd_d = cmd_e'(cmd);
          key_d = key;
          val_d = val;
          if (cmd_e'(cmd) == CMD_CLEAR) begin
            valid_d  = '0;
            tomb_d   = '0;
            probes_d = '0;
            status_d = ST_OK;
            state_d  = S_DONE;
          end else begin
            idx_d     = hash_c;
            count_d   = '0;
            rem_vld_d = 1'b0;
            state_d   = S_PROBE;
          end
        end
      end

      S_PROBE: begin
        idx_d   = idx_q + DW'(1);
        count_d = cnt_next_c;
        if (!slot_vld_c && !rem_vld_q) begin
          rem_vld_d = 1'b1;
          rem_idx_d = idx_q;
        end
        case (cmd_q)
          CMD_LOOKUP: begin
            if (slot_match_c) begin
              status_d = ST_OK;
              out_d    = val_mem_q[idx_q];
              state_d  = S_DONE;
            end else if (slot_empty_c || last_c) begin
              status_d = ST_MISS;
              state_d  = S_DONE;
            end
          end
          CMD_INSERT: begin
            if (slot_match_c) begin
              wr_en_c  = 1'b1;
              wr_idx_c = idx_q;
              status_d = ST_OK;
              state_d  = S_DONE;
            end else if (slot_empty_c || last_c) begin
              state_d = S_DONE;
              // The earliest free slot wins; the current one only if none was seen before.
              if (rem_vld_q) begin
                wr_en_c  = 1'b1;
                wr_idx_c = rem_idx_q;
                status_d = ST_OK;
              end else if (!slot_vld_c) begin
                wr_en_c  = 1'b1;
                wr_idx_c = idx_q;
                status_d = ST_OK;
              end else begin
                status_d = ST_FULL;
              end
            end
          end
          CMD_DELETE: begin
            if (slot_match_c) begin
              valid_d[idx_q] = 1'b0;
              tomb_d[idx_q]  = 1'b1;
              status_d       = ST_OK;
              state_d        = S_DONE;
            end else if (slot_empty_c || last_c) begin
              status_d = ST_MISS;
              state_d  = S_DONE;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
        if (state_d == S_DONE) begin
          probes_d = cnt_next_c;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wr_en_c) begin
      valid_d[wr_idx_c] = 1'b1;
      tomb_d[wr_idx_c]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_LOOKUP;
      status_q  <= ST_NONE;
      key_q     <= '0;
      val_q     <= '0;
      out_q     <= '0;
      idx_q     <= '0;
      rem_idx_q <= '0;
      rem_vld_q <= 1'b0;
      count_q   <= '0;
      probes_q  <= '0;
      go_prev_q <= 1'b1;
      valid_q   <= '0;
      tomb_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      status_q  <= status_d;
      key_q     <= key_d;
      val_q     <= val_d;
      out_q     <= out_d;
      idx_q     <= idx_d;
      rem_idx_q <= rem_idx_d;
      rem_vld_q <= rem_vld_d;
      count_q   <= count_d;
      probes_q  <= probes_d;
      go_prev_q <= go;
      valid_q   <= valid_d;
      tomb_q    <= tomb_d;
    end
  end

  // Key/value payload needs no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      key_mem_q[wr_idx_c] <= key_q;
      val_mem_q[wr_idx_c] <= val_q;
    end
  end

  assign busy   = state_busy(state_q);
  assign done   = (state_q == S_DONE);
  assign status = status_q;
  assign out    = out_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_param_probe_table.sv
// Directed self-checking bench for param_probe_table at default parameters (8 slots, XOR-fold hash).
module tb_param_probe_table;

  logic       clk;
  logic       rst;
  logic [1:0] cmd;
  logic       go;
  logic [3:0] key;
  logic [3:0] val;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [3:0] out;
  logic [3:0] probes;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] C_LOOKUP = 2'b00;
  localparam logic [1:0] C_INSERT = 2'b01;
  localparam logic [1:0] C_DELETE = 2'b10;
  localparam logic [1:0] C_CLEAR  = 2'b11;
  localparam logic [1:0] S_NONE   = 2'b00;
  localparam logic [1:0] S_OK     = 2'b01;
  localparam logic [1:0] S_MISS   = 2'b10;
  localparam logic [1:0] S_FULL   = 2'b11;

  param_probe_table dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd),
    .go     (go),
    .key    (key),
    .val    (val),
    .busy   (busy),
    .done   (done),
    .status (status),
    .out    (out),
    .probes (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise go at a negedge; lat = number of negedges until done is seen (cycle N+lat), 0 on timeout.
  task automatic run_op(input logic [1:0] c, input logic [3:0] k, input logic [3:0] v,
                        output int lat);
    @(negedge clk);
    cmd = c; key = k; val = v; go = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      go = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1; cmd = C_LOOKUP; key = 4'h0; val = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, status, out, probes} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b status=%0d out=%0h probes=%0d, required all 0",
               busy, done, status, out, probes);
    end
    rst = 1'b0;
    begin
      int seen_busy = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy) seen_busy++;
      end
      n_checks++;
      if (seen_busy !== 0) begin
        n_fail++;
        $display("FAIL reset_go_held: busy seen in %0d cycles, required 0", seen_busy);
      end
    end
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lookup_miss();
    int lat;
    run_op(C_LOOKUP, 4'h3, 4'h0, lat);
    n_checks++;
    if (lat !== 2 || status !== S_MISS || probes !== 4'd1 || out !== 4'h0) begin
      n_fail++;
      $display("FAIL lookup_empty: lat=%0d status=%0d probes=%0d out=%0h, required 2/2/1/0",
               lat, status, probes, out);
    end
  endtask

  task automatic test_insert_collide();
    int lat;
    run_op(C_INSERT, 4'h1, 4'h5, lat);
    n_checks++;
    if (lat !== 2 || status !== S_OK || probes !== 4'd1) begin
      n_fail++;
      $display("FAIL insert_1: lat=%0d status=%0d probes=%0d, required 2/1/1", lat, status, probes);
    end
    run_op(C_INSERT, 4'h8, 4'h7, lat);
    n_checks++;
    if (lat !== 3 || status !== S_OK || probes !== 4'd2 || out !== 4'h0) begin
      n_fail++;
      $display("FAIL insert_8: lat=%0d status=%0d probes=%0d out=%0h, required 3/1/2/0",
               lat, status, probes, out);
    end
    run_op(C_LOOKUP, 4'h8, 4'h0, lat);
    n_checks++;
    if (lat !== 3 || status !== S_OK || probes !== 4'd2 || out !== 4'h7) begin
      n_fail++;
      $display("FAIL lookup_8: lat=%0d status=%0d probes=%0d out=%0h, required 3/1/2/7",
               lat, status, probes, out);
    end
  endtask

  task automatic test_delete_tombstone();
    int lat;
    run_op(C_DELETE, 4'h1, 4'h0, lat);
    n_checks++;
    if (status !== S_OK || probes !== 4'd1 || out !== 4'h7) begin
      n_fail++;
      $display("FAIL delete_1: status=%0d probes=%0d out=%0h, required 1/1/7", status, probes, out);
    end
    run_op(C_LOOKUP, 4'h8, 4'h0, lat);
    n_checks++;
    if (status !== S_OK || probes !== 4'd2 || out !== 4'h7) begin
      n_fail++;
      $display("FAIL lookup_past_tomb: status=%0d probes=%0d out=%0h, required 1/2/7",
               status, probes, out);
    end
    run_op(C_INSERT, 4'h8, 4'hA, lat);
    n_checks++;
    if (status !== S_OK || probes !== 4'd2 || out !== 4'h7) begin
      n_fail++;
      $display("FAIL insert_overwrite: status=%0d probes=%0d out=%0h, required 1/2/7",
               status, probes, out);
    end
    run_op(C_LOOKUP, 4'h8, 4'h0, lat);
    n_checks++;
    if (status !== S_OK || out !== 4'hA || probes !== 4'd2) begin
      n_fail++;
      $display("FAIL lookup_overwritten: status=%0d out=%0h probes=%0d, required 1/a/2",
               status, out, probes);
    end
    run_op(C_LOOKUP, 4'h1, 4'h0, lat);
    n_checks++;
    if (status !== S_MISS || probes !== 4'd3 || out !== 4'hA) begin
      n_fail++;
      $display("FAIL lookup_deleted: status=%0d probes=%0d out=%0h, required 2/3/a",
               status, probes, out);
    end
  endtask

  task automatic test_full();
    int lat;
    int bad = 0;
    run_op(C_CLEAR, 4'h0, 4'h0, lat);
    n_checks++;
    if (lat !== 1 || status !== S_OK || probes !== 4'd0 || out !== 4'hA) begin
      n_fail++;
      $display("FAIL clear_latency: lat=%0d status=%0d probes=%0d out=%0h, required 1/1/0/a",
               lat, status, probes, out);
    end
    for (int k = 0; k < 8; k++) begin
      run_op(C_INSERT, 4'(k), 4'(k), lat);
      if (status !== S_OK || probes !== 4'd1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL fill_8: %0d inserts not OK in one probe, required 0", bad);
    end
    run_op(C_INSERT, 4'h9, 4'h2, lat);
    n_checks++;
    if (lat !== 9 || status !== S_FULL || probes !== 4'd8) begin
      n_fail++;
      $display("FAIL insert_full: lat=%0d status=%0d probes=%0d, required 9/3/8", lat, status, probes);
    end
    run_op(C_INSERT, 4'h5, 4'hC, lat);
    n_checks++;
    if (status !== S_OK || probes !== 4'd1) begin
      n_fail++;
      $display("FAIL reinsert_full: status=%0d probes=%0d, required 1/1", status, probes);
    end
    run_op(C_LOOKUP, 4'h5, 4'h0, lat);
    n_checks++;
    if (status !== S_OK || out !== 4'hC) begin
      n_fail++;
      $display("FAIL lookup_reinsert: status=%0d out=%0h, required 1/c", status, out);
    end
    run_op(C_LOOKUP, 4'h9, 4'h0, lat);
    n_checks++;
    if (status !== S_MISS || probes !== 4'd8 || out !== 4'hC) begin
      n_fail++;
      $display("FAIL lookup_wrap_miss: status=%0d probes=%0d out=%0h, required 2/8/c",
               status, probes, out);
    end
  endtask

  task automatic test_go_held();
    int pulses = 0;
    @(negedge clk);
    cmd = C_LOOKUP; key = 4'h3; go = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    go = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 1 || out !== 4'h3) begin
      n_fail++;
      $display("FAIL go_held: done pulses=%0d out=%0h, required 1/3", pulses, out);
    end
  endtask

  task automatic test_clear_then_abort();
    int lat;
    run_op(C_CLEAR, 4'h0, 4'h0, lat);
    n_checks++;
    if (lat !== 1 || status !== S_OK) begin
      n_fail++;
      $display("FAIL clear_2: lat=%0d status=%0d, required 1/1", lat, status);
    end
    run_op(C_LOOKUP, 4'h1, 4'h0, lat);
    n_checks++;
    if (status !== S_MISS || probes !== 4'd1) begin
      n_fail++;
      $display("FAIL lookup_after_clear: status=%0d probes=%0d, required 2/1", status, probes);
    end
    run_op(C_INSERT, 4'h1, 4'h5, lat);
    // INSERT 8 must probe slot 1 then slot 2; reset lands inside the second probe cycle.
    @(negedge clk);
    cmd = C_INSERT; key = 4'h8; val = 4'h6; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || status !== S_NONE) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%0b done=%0b status=%0d, required 0/0/0", busy, done, status);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(C_LOOKUP, 4'h8, 4'h0, lat);
    n_checks++;
    if (lat !== 2 || status !== S_MISS || probes !== 4'd1 || out !== 4'h0) begin
      n_fail++;
      $display("FAIL abort_no_entry: lat=%0d status=%0d probes=%0d out=%0h, required 2/2/1/0",
               lat, status, probes, out);
    end
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_insert_collide();
    test_delete_tombstone();
    test_full();
    test_go_held();
    test_clear_then_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_probe_table.md
PARAM_PROBE_TABLE -- requirements
Module: param_probe_table

Interface
REQ-001 SHALL have parameter KEY_W, default 4, key width in bits.
REQ-002 SHALL have parameter VAL_W, default 4, value width in bits.
REQ-003 SHALL have parameter DEPTH_LOG2, default 3, table holds DEPTH = 2^DEPTH_LOG2 slots.
REQ-004 SHALL have parameter HASH_MODE, default 0: 0 = XOR-fold, 1 = low-bits.
REQ-005 SHALL have ports, in order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd  input  2  00 LOOKUP, 01 INSERT, 10 DELETE, 11 CLEAR.
- go  input  1  level request; start on 0->1 transition.
- key  input  KEY_W  operation key.
- val  input  VAL_W  insert value.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- status  output  2  00 NONE, 01 OK, 10 MISS, 11 FULL.
- out  output  VAL_W  value returned by last successful LOOKUP.
- probes  output  DEPTH_LOG2+1  slots examined by the last operation.

Function
REQ-006 SHALL store per slot: key, value, valid bit, tombstone bit.
REQ-007 SHALL compute hash h: HASH_MODE 0 = XOR of all DEPTH_LOG2-bit chunks of key, top chunk zero-padded at its MSBs; HASH_MODE 1 = key[DEPTH_LOG2-1:0], zero-extended if KEY_W < DEPTH_LOG2.
REQ-008 SHALL have states IDLE, PROBE, DONE.
REQ-009 SHALL accept a request only in IDLE when go=1 and go was 0 the previous cycle; cmd/key/val latched at that edge; go edges in PROBE/DONE ignored and not queued.
REQ-010 On accept, non-CLEAR: idx=h, count=0, state -> PROBE; CLEAR: all valid and tombstone bits cleared at that edge, probes=0, status=OK, state -> DONE.
REQ-011 Each PROBE cycle SHALL examine exactly slot idx, then idx=(idx+1) mod DEPTH, count+1.
REQ-012 LOOKUP terminates: valid and key match -> OK, out=slot value; empty slot (not valid, not tombstone) -> MISS; count reaching DEPTH -> MISS; tombstones skipped.
REQ-013 INSERT SHALL remember the first empty-or-tombstone slot; key match -> overwrite value, OK; empty slot or DEPTH probes reached -> write into remembered slot (valid=1, tombstone=0), OK; none remembered -> FULL, table unchanged.
REQ-014 DELETE: key match -> valid=0, tombstone=1, OK; empty slot or DEPTH probes -> MISS.
REQ-015 On termination edge SHALL update status, probes (slots examined, 1..DEPTH), out (LOOKUP hit only) and enter DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-017 busy SHALL be 1 in PROBE and DONE, 0 in IDLE.
REQ-018 Latency: accept edge N; first-probe termination -> done high in cycle N+2; k probes -> N+1+k; CLEAR -> N+1.
REQ-019 status, out, probes SHALL hold until the next termination.
REQ-020 out SHALL be unchanged by MISS, FULL, INSERT, DELETE, CLEAR.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, busy=0, done=0, status=NONE, out=0, probes=0, all valid and tombstone bits 0.
REQ-022 rst during PROBE SHALL abort with no slot written.
REQ-023 Stored key/value contents need not be reset.
REQ-024 go-edge history SHALL reset to 1, so go held high through reset deassertion is not an accept.

Structure
REQ-025 Package ht_pkg SHALL hold cmd encoding, status encoding, state encoding.
REQ-026 Hash SHALL be sub-module ht_hash (KEY_W, DEPTH_LOG2, HASH_MODE), purely combinational.
REQ-027 Storage SHALL be flops; no SRAM macro.

Verification (defaults; key 0x1 and 0x8 hash to slot 1, 0x9 to slot 0)
REQ-028 Reset, LOOKUP key 3 -> done at N+2, status MISS, probes 1, out 0.
REQ-029 INSERT (1,5), INSERT (8,7) -> OK, probes 1 then 2; LOOKUP 8 -> OK, out 7, probes 2.
REQ-030 After REQ-029, DELETE 1 -> OK; LOOKUP 8 -> OK, out 7, probes 2; INSERT (8,0xA) -> OK; LOOKUP 8 -> out 0xA.
REQ-031 Insert 8 distinct keys, INSERT 9th -> FULL, probes 8; re-INSERT existing key -> OK; go held high 20 cycles -> single operation.
REQ-032 CLEAR -> done at N+1, status OK; LOOKUP 1 -> MISS, probes 1; rst in second PROBE cycle of an INSERT -> busy 0 at once, no entry added.
